// File: rtl/rom_dma_batch_sched.sv
// Splits one ROM->SVM transfer command into DMA batches of at most MAX_BATCH_BYTES.
// Optional per-batch watchdog enabled by defining SCHED_TIMEOUT_EN.
module rom_dma_batch_sched #(
  parameter int MAX_BATCH_BYTES = 256,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_base_addr,
  input  logic [31:0] cmd_num_bytes,
  input  logic        abort,
  output logic        start_rd,
  output logic        cfg_ready,
  output logic [31:0] cfg_dma_base_addr,
  output logic [31:0] cfg_dma_num_bytes,
  input  logic        batch_dma_done,
  output logic        busy,
  output logic        cmd_done,
  output logic        aborted,
  output logic        err_timeout,
  output logic [15:0] batches_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  localparam logic [31:0] MAX_B   = 32'(MAX_BATCH_BYTES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] rem;
  logic [31:0] addr_nxt, rem_nxt;
  logic        to_hit;

  function automatic logic [31:0] clip(input logic [31:0] r);
    return (r > MAX_B) ? MAX_B : r;
  endfunction

  // cfg_dma_* doubles as the running address/chunk of the batch in flight
  assign addr_nxt = cfg_dma_base_addr + cfg_dma_num_bytes;
  assign rem_nxt  = rem - cfg_dma_num_bytes;

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] wdog;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wdog <= '0;
    else if (state == WAIT)  wdog <= wdog + 16'd1;
    else                     wdog <= '0;
  end

  assign to_hit = (wdog == TO_LAST);
`else
  logic unused_to;
  assign unused_to = ^TO_LAST;
  assign to_hit    = 1'b0;
`endif

  assign cmd_rdy   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign start_rd  = (state == ISSUE);
  assign cfg_ready = (state == ISSUE) || (state == WAIT);
  assign cmd_done  = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rem               <= '0;
      cfg_dma_base_addr <= '0;
      cfg_dma_num_bytes <= '0;
      batches_done      <= '0;
      aborted           <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      aborted <= 1'b0;
      case (state)
        IDLE: if (cmd_vld) begin
          rem          <= cmd_num_bytes;
          batches_done <= '0;
          err_timeout  <= 1'b0;
          if (cmd_num_bytes == 32'd0) begin
            state <= DONE;
          end else begin
            cfg_dma_base_addr <= cmd_base_addr;
            cfg_dma_num_bytes <= clip(cmd_num_bytes);
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (batch_dma_done) begin
            rem          <= rem_nxt;
            batches_done <= batches_done + 16'd1;
            if (rem_nxt != 32'd0) begin
              cfg_dma_base_addr <= addr_nxt;
              cfg_dma_num_bytes <= clip(rem_nxt);
              state             <= ISSUE;
            end else begin
              state <= DONE;
            end
          end else if (to_hit) begin
            state       <= ERR;
            err_timeout <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        ERR: if (abort) begin
          state   <= IDLE;
          aborted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dma_batch_sched.sv
// Directed bench for rom_dma_batch_sched (MAX 256, TIMEOUT 20); timeout steps need SCHED_TIMEOUT_EN.
module tb_rom_dma_batch_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [31:0] cmd_base_addr = '0;
  logic [31:0] cmd_num_bytes = '0;
  logic        abort = 1'b0;
  logic        start_rd, cfg_ready, busy, cmd_done, aborted, err_timeout;
  logic [31:0] cfg_dma_base_addr, cfg_dma_num_bytes;
  logic        batch_dma_done = 1'b0;
  logic [15:0] batches_done;
  int checks = 0;
  int errors = 0;

  rom_dma_batch_sched #(.MAX_BATCH_BYTES(256), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_base_addr(cmd_base_addr), .cmd_num_bytes(cmd_num_bytes), .abort(abort),
    .start_rd(start_rd), .cfg_ready(cfg_ready), .cfg_dma_base_addr(cfg_dma_base_addr),
    .cfg_dma_num_bytes(cfg_dma_num_bytes), .batch_dma_done(batch_dma_done), .busy(busy),
    .cmd_done(cmd_done), .aborted(aborted), .err_timeout(err_timeout),
    .batches_done(batches_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] n);
    cmd_base_addr = a;
    cmd_num_bytes = n;
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
  endtask

  // Checks the issued batch, holds WAIT for a few cycles, then answers done.
  task automatic do_batch(input logic [31:0] a, input logic [31:0] n);
    int k = 0;
    while (!start_rd && k < 20) begin tick(); k++; end
    chk("start_rd", start_rd, 1);
    chk("cfg_ready_issue", cfg_ready, 1);
    chk("cfg_addr", cfg_dma_base_addr, a);
    chk("cfg_len", cfg_dma_num_bytes, n);
    tick();
    chk("start_rd_pulse", start_rd, 0);
    repeat (3) tick();
    chk("cfg_ready_wait", cfg_ready, 1);
    chk("cfg_addr_hold", cfg_dma_base_addr, a);
    batch_dma_done = 1'b1;
    tick();
    batch_dma_done = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start_rd", start_rd, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_addr", cfg_dma_base_addr, 0);
    chk("rst_batches", batches_done, 0);
    chk("rst_err", err_timeout, 0);
    #10 reset = 1'b0;
    tick();

    // 600 bytes in three batches
    send(32'h0000_1000, 600);
    chk("t1_accept_start", start_rd, 1);
    do_batch(32'h1000, 256);
    chk("t1_bubble_issue", start_rd, 1);
    do_batch(32'h1100, 256);
    do_batch(32'h1200, 88);
    chk("t1_cmd_done", cmd_done, 1);
    chk("t1_batches", batches_done, 3);
    chk("t1_rdy_low", cmd_rdy, 0);
    chk("t1_cfg_ready_fall", cfg_ready, 0);
    tick();
    chk("t1_done_pulse", cmd_done, 0);
    chk("t1_rdy", cmd_rdy, 1);

    // address wrap across 2^32
    send(32'hFFFF_FF00, 512);
    do_batch(32'hFFFF_FF00, 256);
    do_batch(32'h0000_0000, 256);
    chk("t2_cmd_done", cmd_done, 1);
    chk("t2_batches", batches_done, 2);
    tick();

    // zero-length command
    send(32'h0000_0040, 0);
    chk("t3_cmd_done", cmd_done, 1);
    chk("t3_no_start", start_rd, 0);
    chk("t3_batches", batches_done, 0);
    chk("t3_cfg_hold", cfg_dma_base_addr, 0);
    tick();
    chk("t3_rdy", cmd_rdy, 1);

    // abort in the second WAIT, with a simultaneous done
    send(32'h0000_2000, 1024);
    do_batch(32'h2000, 256);
    tick();
    tick();
    abort = 1'b1;
    batch_dma_done = 1'b1;
    tick();
    abort = 1'b0;
    batch_dma_done = 1'b0;
    chk("t4_aborted", aborted, 1);
    chk("t4_rdy", cmd_rdy, 1);
    chk("t4_no_done", cmd_done, 0);
    chk("t4_batches", batches_done, 1);
    batch_dma_done = 1'b1;
    tick();
    batch_dma_done = 1'b0;
    chk("t4_late_done", batches_done, 1);
    chk("t4_aborted_pulse", aborted, 0);
    chk("t4_idle", busy, 0);

`ifdef SCHED_TIMEOUT_EN
    send(32'h0000_3000, 100);
    repeat (20) tick();
    chk("t5_no_err_yet", err_timeout, 0);
    tick();
    chk("t5_err", err_timeout, 1);
    chk("t5_cfg_ready", cfg_ready, 0);
    repeat (5) tick();
    chk("t5_err_hold", err_timeout, 1);
    chk("t5_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_aborted", aborted, 1);
    chk("t5_rdy", cmd_rdy, 1);
    chk("t5_err_sticky", err_timeout, 1);
    send(32'h0000_0000, 0);
    chk("t5_err_clear", err_timeout, 0);
    tick();
`else
    send(32'h0000_3000, 100);
    repeat (30) tick();
    chk("t5_no_timeout", err_timeout, 0);
    chk("t5_still_wait", cfg_ready, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_aborted", aborted, 1);
`endif

    // asynchronous reset in WAIT, then a normal command
    send(32'h0000_4000, 300);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rdy", cmd_rdy, 1);
    chk("t6_cfg_ready", cfg_ready, 0);
    chk("t6_cfg_addr", cfg_dma_base_addr, 0);
    chk("t6_cfg_len", cfg_dma_num_bytes, 0);
    chk("t6_busy", busy, 0);
    #3 reset = 1'b0;
    tick();
    send(32'h0000_5000, 8);
    do_batch(32'h5000, 8);
    chk("t6_cmd_done", cmd_done, 1);
    chk("t6_batches", batches_done, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_dma_batch_sched.md
# rom_dma_batch_sched

Batch scheduler placed in front of `rom_dma_top`. It accepts one ROM-to-SVM transfer command (base address and total byte count) and splits it into DMA batches of at most `MAX_BATCH_BYTES`. For each batch it drives the `start_rd`/`cfg_*` configuration, then waits for `batch_dma_done` before advancing. It replaces the static configuration previously driven from `svm_core_top`, and reports completion, batch count and a per-batch timeout error.

## Interface
Parameters:
- `MAX_BATCH_BYTES`, default 256: largest single DMA batch in bytes, power of two, ≥4.
- `TIMEOUT_CYCLES`, default 65535: `WAIT` cycles before a batch is declared hung. 16-bit counter; only used with `SCHED_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: high only in `IDLE`.
- `cmd_base_addr` in 32: first ROM byte address.
- `cmd_num_bytes` in 32: total bytes to move.
- `abort` in 1: synchronous abort of the current command.
- `start_rd` out 1: one-cycle pulse per batch, to `rom_dma_top`.
- `cfg_ready` out 1: `cfg_dma_*` valid and stable.
- `cfg_dma_base_addr` out 32: current batch address.
- `cfg_dma_num_bytes` out 32: current batch length.
- `batch_dma_done` in 1: DMA batch completion.
- `busy` out 1: state ≠ `IDLE`.
- `cmd_done` out 1: one-cycle pulse when the command finishes.
- `aborted` out 1: one-cycle pulse when an abort is taken.
- `err_timeout` out 1: sticky timeout flag.
- `batches_done` out 16: batches completed in the current or last command; wraps.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `DONE`, `ERR`.
- `IDLE`:
  - On `cmd_vld & cmd_rdy`, latch `addr=cmd_base_addr` and `rem=cmd_num_bytes`, and clear `batches_done`.
  - If `rem==0` go to `DONE`; otherwise go to `ISSUE`.
- `ISSUE` (exactly one cycle):
  - `chunk = min(rem, MAX_BATCH_BYTES)`.
  - Drive `cfg_dma_base_addr=addr`, `cfg_dma_num_bytes=chunk`, `start_rd=1`.
  - Go to `WAIT`.
- `WAIT`:
  - Hold `cfg_*` stable and keep `cfg_ready=1`.
  - On `batch_dma_done`: `addr += chunk` (mod 2^32, wraps silently), `rem -= chunk`, `batches_done += 1`. Go to `ISSUE` if the new `rem ≠ 0`, else go to `DONE`.
- `DONE`: pulse `cmd_done` for one cycle, then go to `IDLE`.
- `ERR`:
  - `err_timeout=1`; `cfg_ready` and `start_rd` are 0.
  - Leaves only on `abort`, going to `IDLE` with an `aborted` pulse.
  - `err_timeout` clears on the next accepted command.
- `abort` in `ISSUE` or `WAIT`:
  - Go to `IDLE` on the next edge and pulse `aborted`.
  - No `cmd_done` pulse; `batches_done` is frozen.
  - A `batch_dma_done` arriving in the same cycle is ignored.
- `abort` in `IDLE` or `DONE` has no effect.
- `batch_dma_done` outside `WAIT` is ignored.
- `cmd_vld` while busy is not accepted; the command must be held until `cmd_rdy`.
- `cfg_dma_*` hold their last values when not in `ISSUE`/`WAIT`; consumers qualify them with `cfg_ready`.

## Timing
- Reset values: state `IDLE`, `cmd_rdy=1`, all other outputs 0, `cfg_dma_*`=0, internal counters 0.
- Command accepted at edge T:
  - `ISSUE` during T+1: `start_rd=1`, `cfg_ready=1`.
  - `WAIT` from T+2.
- `batch_dma_done` sampled high at edge D:
  - Next `ISSUE` during D+1, giving a 1-cycle bubble between batches.
  - Or `cmd_done` high during D+1, and `cmd_rdy=1` from D+2.
- Zero-length command accepted at T: `cmd_done` during T+1, `cmd_rdy` during T+2.
- `cfg_ready` rises together with `start_rd` and falls the cycle after `batch_dma_done`, unless the next batch is issued.
- Reset mid-operation aborts with no `cmd_done`/`aborted` pulse; `rom_dma_top` is reset alongside.

## Configuration
- Macro `SCHED_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog clears on entry to `WAIT` and increments each `WAIT` cycle.
  - When it reaches `TIMEOUT_CYCLES` without `batch_dma_done`, the next state is `ERR`.
  - If `batch_dma_done` arrives in the same cycle as the terminal count, done wins.
- Undefined: no counter, `ERR` is unreachable, and `err_timeout` is tied to 0.

## Test plan
- Base 0x0000_1000, 600 bytes, MAX 256, DMA done 5 cycles after each `start_rd`:
  - Three `start_rd` pulses with (0x1000,256), (0x1100,256), (0x1200,88).
  - Then `cmd_done` and `batches_done=3`.
- Base 0xFFFF_FF80, 256 bytes, MAX 128: batches (0xFFFF_FF80,128) then (0x0000_0000,128), showing address wrap.
- 0 bytes: `cmd_done` one cycle after accept, no `start_rd`, `batches_done=0`.
- `abort` during the second `WAIT` of a 1024-byte command: `aborted` pulse, `batches_done=1`, `cmd_rdy` next cycle; a late `batch_dma_done` is ignored.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES=20`, DMA never answers:
  - `err_timeout` asserts after the 20th `WAIT` cycle and holds.
  - `abort` returns to `IDLE`; the next command clears the flag.
- `reset` asserted mid-`WAIT`: all outputs drop to reset values asynchronously; a new command after release runs normally.
